sfifo_ctrl: RTL and testbench
=============================

SFIFO_CTRL -- requirements
Module: sfifo_ctrl

Interface
REQ-001 SHALL have parameter depth, default 8, number of RAM entries (power of two).
REQ-002 SHALL have parameter width, default 16, RAM data width (passed through, unused internally).
REQ-003 SHALL have parameter addr, default 3, address width; depth SHALL equal 2**addr.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous and active-low.
REQ-006 SHALL have port push, input, 1, upstream write request.
REQ-007 SHALL have port pop, input, 1, downstream read request.
REQ-008 SHALL have port wr, output, 1, RAM write enable.
REQ-009 SHALL have port rd, output, 1, RAM read enable.
REQ-010 SHALL have port wraddr, output, addr, RAM write address.
REQ-011 SHALL have port rdaddr, output, addr, RAM read address.
REQ-012 SHALL have port full, output, 1, high when count == depth.
REQ-013 SHALL have port empty, output, 1, high when count == 0.
REQ-014 SHALL have port count, output, addr+1, current occupancy, 0..depth.
REQ-015 SHALL have port ovf, output, 1, sticky flag: push attempted while full.
REQ-016 SHALL have port unf, output, 1, sticky flag: pop attempted while empty.

Function
REQ-017 SHALL accept a push iff push && !full; wr SHALL equal this term combinationally.
REQ-018 SHALL accept a pop iff pop && !empty; rd SHALL equal this term combinationally.
REQ-019 SHALL drive wraddr from registered write pointer; pointer increments by 1 on each accepted push, wrapping depth-1 -> 0.
REQ-020 SHALL drive rdaddr from registered read pointer; pointer increments by 1 on each accepted pop, wrapping depth-1 -> 0.
REQ-021 SHALL update count next edge: +1 push only, -1 pop only, unchanged for both or neither.
REQ-022 SHALL, when full and push && pop, accept only the pop: count -> depth-1, wraddr unchanged.
REQ-023 SHALL, when empty and push && pop, accept only the push: count -> 1, rdaddr unchanged.
REQ-024 SHALL decode full and empty combinationally from registered count; neither SHALL glitch on input changes.
REQ-025 SHALL set ovf on an edge where push && full, and unf on an edge where pop && empty; both hold until reset.
REQ-026 SHALL not alter pointers or count on a rejected request.
REQ-027 SHALL make data written at address A readable when rdaddr == A; RAM dout latency is owned by the RAM.

Reset
REQ-028 SHALL on rst low, independent of clk, force wraddr=0, rdaddr=0, count=0, empty=1, full=0, ovf=0, unf=0, wr=0, rd=0.
REQ-029 SHALL hold reset values while rst is low regardless of push/pop.
REQ-030 SHALL, on reset asserted mid-operation, discard all occupancy; first accepted push after release writes address 0.

Configuration
REQ-031 SHALL, with macro SFIFO_ALMOST_FLAGS_EN defined, add outputs almost_full (count >= depth-1) and almost_empty (count <= 1), both reset to almost_full=0, almost_empty=1.
REQ-032 SHALL, without SFIFO_ALMOST_FLAGS_EN, omit both ports and their logic; all other behaviour identical.

Verification
REQ-033 Reset: rst=0 at t=3 (mid clk high) -> all outputs at reset values immediately, empty=1, count=0.
REQ-034 Fill: 8 consecutive pushes from empty -> wraddr 0..7 then wraps to 0, count=8, full=1; 9th push -> wr=0, ovf=1, count stays 8.
REQ-035 Drain: 8 pops from full -> rdaddr 0..7 then 0, count=0, empty=1; extra pop -> rd=0, unf=1.
REQ-036 Simultaneous: count=4, push&&pop for 3 cycles -> count stays 4, both pointers advance by 3.
REQ-037 Boundary: full with push&&pop -> count=7, only rdaddr advances; empty with push&&pop -> count=1, only wraddr advances.
REQ-038 With SFIFO_ALMOST_FLAGS_EN: push to count=7 -> almost_full=1, full=0; pop to count=1 -> almost_empty=1, empty=0.

Source files
------------

// File: rtl/sfifo_ctrl.sv
// ---------------------------------------------------------------------------
// sfifo_ctrl -- control logic for a single-clock FIFO built around an external
// simple dual-port RAM. The block owns the write/read pointers, the occupancy
// counter and the status flags; the RAM itself (and its read latency) lives
// outside this module.
//
// Parameters
//   depth  : number of RAM entries, must equal 2**addr
//   width  : RAM data width (carried for the integrator, not used here)
//   addr   : RAM address width
//
// Ports
//   clk          in   single clock, all state updates on its rising edge
//   rst          in   asynchronous, active-low reset
//   push         in   upstream write request
//   pop          in   downstream read request
//   wr           out  RAM write enable (push accepted this cycle)
//   rd           out  RAM read enable  (pop accepted this cycle)
//   wraddr       out  RAM write address (registered write pointer)
//   rdaddr       out  RAM read address  (registered read pointer)
//   full         out  count == depth
//   empty        out  count == 0
//   count        out  occupancy, 0..depth
//   ovf          out  sticky: push attempted while full
//   unf          out  sticky: pop attempted while empty
//   almost_full  out  count >= depth-1   (only with SFIFO_ALMOST_FLAGS_EN)
//   almost_empty out  count <= 1         (only with SFIFO_ALMOST_FLAGS_EN)
//
// Build option
//   SFIFO_ALMOST_FLAGS_EN : when defined, adds the almost_full/almost_empty
//                           outputs; when undefined they do not exist.
// ---------------------------------------------------------------------------
module sfifo_ctrl #(
  parameter int depth = 8,
  parameter int width = 16,
  parameter int addr  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  output logic            wr,
  output logic            rd,
  output logic [addr-1:0] wraddr,
  output logic [addr-1:0] rdaddr,
  output logic            full,
  output logic            empty,
  output logic [addr:0]   count,
  output logic            ovf,
  output logic            unf
`ifdef SFIFO_ALMOST_FLAGS_EN
  ,
  output logic            almost_full,
  output logic            almost_empty
`endif
);

  // Occupancy value that means "every entry holds data".
  localparam logic [addr:0] FULL_CNT = (addr+1)'(depth);

  // Pointer arithmetic relies on natural wrap of an addr-bit counter, so the
  // depth has to be an exact power of two matching addr.
  if ((depth != (1 << addr)) || (width < 1)) begin : g_bad_cfg
    $error("sfifo_ctrl: depth must equal 2**addr and width must be positive");
  end

  logic [addr-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr:0]   count_q,  count_d;
  logic            ovf_q,    ovf_d;
  logic            unf_q,    unf_d;
  logic            push_ok;
  logic            pop_ok;

  // Flags come straight from the registered count, so input activity can
  // never make them glitch.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Accept terms. The rst term keeps the RAM strobes quiet while reset is
  // held, even though full/empty alone would already block a pop.
  assign push_ok = push & ~full  & rst;
  assign pop_ok  = pop  & ~empty & rst;

  assign wr     = push_ok;
  assign rd     = pop_ok;
  assign wraddr = wr_ptr_q;
  assign rdaddr = rd_ptr_q;
  assign count  = count_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;

    // When full (or empty) with both requests, only one side is accepted,
    // so the count still moves by one in that case.
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Sticky error flags: any attempt against a full/empty FIFO, including
    // the simultaneous push+pop boundary cases.
    if (push && full)  ovf_d = 1'b1;
    if (pop  && empty) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

`ifdef SFIFO_ALMOST_FLAGS_EN
  // Reset count of zero yields almost_full=0, almost_empty=1 automatically.
  assign almost_full  = (count_q >= (FULL_CNT - 1'b1));
  assign almost_empty = (count_q <= (addr+1)'(1));
`endif

endmodule

// File: tb/tb_sfifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sfifo_ctrl -- directed self-checking bench for sfifo_ctrl (default
// parameters: depth 8, addr 3). Inputs change just after the falling edge;
// combinational outputs are checked before the next rising edge and
// registered outputs 1 time unit after it.
// ---------------------------------------------------------------------------
module tb_sfifo_ctrl;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic       wr;
  logic       rd;
  logic [2:0] wraddr;
  logic [2:0] rdaddr;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       ovf;
  logic       unf;
`ifdef SFIFO_ALMOST_FLAGS_EN
  logic       almost_full;
  logic       almost_empty;
`endif

  int n_cmp = 0;
  int n_err = 0;

  sfifo_ctrl #(.depth(8), .width(16), .addr(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr     (wr),
    .rd     (rd),
    .wraddr (wraddr),
    .rdaddr (rdaddr),
    .full   (full),
    .empty  (empty),
    .count  (count),
    .ovf    (ovf),
    .unf    (unf)
`ifdef SFIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // Clock starts high: high 0..5, low 5..10, rising edges at 10, 20, ...
  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, input logic q);
    @(negedge clk);
    push = p;
    pop  = q;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    push = 1'b0;
    pop  = 1'b0;

    // Asynchronous reset in the middle of the clock-high phase.
    #3 rst = 1'b0;
    #1;
    chk("rst_wraddr", 32'(wraddr), 0);
    chk("rst_rdaddr", 32'(rdaddr), 0);
    chk("rst_count",  32'(count),  0);
    chk("rst_empty",  32'(empty),  1);
    chk("rst_full",   32'(full),   0);
    chk("rst_ovf",    32'(ovf),    0);
    chk("rst_unf",    32'(unf),    0);
    chk("rst_wr",     32'(wr),     0);
    chk("rst_rd",     32'(rd),     0);
`ifdef SFIFO_ALMOST_FLAGS_EN
    chk("rst_afull",  32'(almost_full),  0);
    chk("rst_aempty", 32'(almost_empty), 1);
`endif

    // Requests while reset is held are ignored.
    drive(1'b1, 1'b1);
    chk("rsthold_wr", 32'(wr), 0);
    chk("rsthold_rd", 32'(rd), 0);
    tick();
    chk("rsthold_count",  32'(count),  0);
    chk("rsthold_wraddr", 32'(wraddr), 0);

    // Release reset.
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
    rst  = 1'b1;

    // Fill: 8 pushes, write address walks 0..7.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0);
      chk("fill_wr",     32'(wr),     1);
      chk("fill_wraddr", 32'(wraddr), 32'(i));
      tick();
      chk("fill_count",  32'(count),  32'(i + 1));
    end
    chk("fill_wrap",  32'(wraddr), 0);
    chk("fill_full",  32'(full),   1);
    chk("fill_empty", 32'(empty),  0);
    chk("fill_ovf0",  32'(ovf),    0);

    // 9th push is rejected and flags overflow.
    drive(1'b1, 1'b0);
    chk("ovf_wr", 32'(wr), 0);
    tick();
    chk("ovf_flag",   32'(ovf),    1);
    chk("ovf_count",  32'(count),  8);
    chk("ovf_wraddr", 32'(wraddr), 0);

    // Drain: 8 pops, read address walks 0..7.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1);
      chk("drain_rd",     32'(rd),     1);
      chk("drain_rdaddr", 32'(rdaddr), 32'(i));
      tick();
      chk("drain_count",  32'(count),  32'(7 - i));
    end
    chk("drain_wrap",  32'(rdaddr), 0);
    chk("drain_empty", 32'(empty),  1);
    chk("drain_unf0",  32'(unf),    0);
    chk("ovf_sticky",  32'(ovf),    1);

    // Extra pop is rejected and flags underflow.
    drive(1'b0, 1'b1);
    chk("unf_rd", 32'(rd), 0);
    tick();
    chk("unf_flag",   32'(unf),    1);
    chk("unf_count",  32'(count),  0);
    chk("unf_rdaddr", 32'(rdaddr), 0);

    // Simultaneous push+pop at count 4.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0);
      tick();
    end
    chk("sim_pre_count", 32'(count), 4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1);
      chk("sim_wr", 32'(wr), 1);
      chk("sim_rd", 32'(rd), 1);
      tick();
      chk("sim_count", 32'(count), 4);
    end
    chk("sim_wraddr", 32'(wraddr), 7);
    chk("sim_rdaddr", 32'(rdaddr), 3);

    // Boundary: full with push+pop accepts only the pop.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0);
      tick();
    end
    chk("bfull_full",   32'(full),   1);
    chk("bfull_wraddr", 32'(wraddr), 3);
    drive(1'b1, 1'b1);
    chk("bfull_wr", 32'(wr), 0);
    chk("bfull_rd", 32'(rd), 1);
    tick();
    chk("bfull_count",  32'(count),  7);
    chk("bfull_wraddr2", 32'(wraddr), 3);
    chk("bfull_rdaddr", 32'(rdaddr), 4);
    chk("bfull_notfull", 32'(full),  0);
`ifdef SFIFO_ALMOST_FLAGS_EN
    chk("afull_at7",   32'(almost_full),  1);
    chk("aempty_at7",  32'(almost_empty), 0);
`endif

    // Pop down to 1, then to empty.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1);
      tick();
    end
    chk("bempty_count1", 32'(count),  1);
    chk("bempty_rdaddr", 32'(rdaddr), 2);
    chk("bempty_notempty", 32'(empty), 0);
`ifdef SFIFO_ALMOST_FLAGS_EN
    chk("aempty_at1", 32'(almost_empty), 1);
    chk("afull_at1",  32'(almost_full),  0);
`endif
    drive(1'b0, 1'b1);
    tick();
    chk("bempty_empty", 32'(empty), 1);

    // Boundary: empty with push+pop accepts only the push.
    drive(1'b1, 1'b1);
    chk("bempty_wr", 32'(wr), 1);
    chk("bempty_rd", 32'(rd), 0);
    tick();
    chk("bempty_count",   32'(count),  1);
    chk("bempty_wraddr",  32'(wraddr), 4);
    chk("bempty_rdaddr2", 32'(rdaddr), 3);

    // Reset mid-operation discards occupancy and sticky flags.
    drive(1'b1, 1'b0);
    tick();
    chk("mid_pre_count", 32'(count), 2);
    @(negedge clk);
    push = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_count",  32'(count),  0);
    chk("mid_wraddr", 32'(wraddr), 0);
    chk("mid_rdaddr", 32'(rdaddr), 0);
    chk("mid_ovf",    32'(ovf),    0);
    chk("mid_unf",    32'(unf),    0);
    chk("mid_empty",  32'(empty),  1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0);
    chk("post_wr",     32'(wr),     1);
    chk("post_wraddr", 32'(wraddr), 0);
    tick();
    chk("post_count",   32'(count),  1);
    chk("post_wraddr1", 32'(wraddr), 1);

    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
